exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter W, default 8, data width; all data ports W bits, shift amount is operand_a[2:0].
REQ-002 clk  input  1  sole clock, all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to execute op; sampled only in IDLE.
REQ-005 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SHL, 7 SHR, 8 MUL, 9 CMP, 10-15 illegal.
REQ-006 operand_a  input  W  register-file read operand (do_a).
REQ-007 operand_acc  input  W  current accumulator value (do_acc).
REQ-008 busy  output  1  high in EXEC and DONE states.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  W  registered result; drives accumulator input; holds between completions.
REQ-011 wr_en  output  1  register-file write enable; equals done AND op writes (not CMP, not illegal).
REQ-012 zero  output  1  registered zero flag.
REQ-013 carry  output  1  registered carry/borrow flag.
REQ-014 illegal  output  1  one-cycle pulse with done when latched op is 10-15.

Function
REQ-015 FSM states IDLE, EXEC, DONE; IDLE->DONE for single-cycle ops and zero-count shifts, IDLE->EXEC for MUL and nonzero shifts, EXEC->DONE when count reaches zero, DONE->IDLE unconditionally.
REQ-016 On posedge in IDLE with start=1, op, operand_a and operand_acc shall be latched; later input changes shall not affect the operation.
REQ-017 start while busy=1 shall be ignored and not queued; start asserted in the DONE cycle shall be ignored.
REQ-018 Single-cycle ops (ADD, SUB, AND, OR, XOR, MOV, CMP, illegal): done high in the cycle after the accepting edge (latency 1).
REQ-019 Arithmetic is acc op a modulo 2^W: ADD carry=carry-out; SUB carry=borrow (acc<a); AND/OR/XOR/MOV carry=0; MOV result=a.
REQ-020 CMP computes acc-a for flags only; result register unchanged; wr_en=0.
REQ-021 SHL/SHR shift acc one bit per EXEC cycle, zero fill, by k=a[2:0]; latency k+1; carry=last bit shifted out; k=0 gives result=acc, carry=0, latency 1.
REQ-022 MUL uses shift-add, exactly 8 EXEC cycles, latency 9; result=low W bits of acc*a; carry=1 iff high W bits nonzero.
REQ-023 Illegal op: result unchanged, flags unchanged, wr_en=0, illegal=1 with done.
REQ-024 zero=(value==0), where value is the new result, or acc-a for CMP; result and flags update only at the edge entering DONE.
REQ-025 result, zero, carry hold value in all other cycles; done, wr_en, illegal low outside DONE.

Reset
REQ-026 reset=1 at posedge shall force IDLE, result=0, zero=0, carry=0, done=0, wr_en=0, illegal=0, busy=0, clear counter and latches.
REQ-027 reset overrides start and any in-progress operation; an aborted op shall produce no done, wr_en, or result/flag update.
REQ-028 First start is accepted on the first posedge after reset deasserts.

Verification
REQ-029 ADD acc=0xF0, a=0x20, start 1 cycle -> next cycle done=1, wr_en=1, result=0x10, carry=1, zero=0, busy=1.
REQ-030 SUB acc=0x05, a=0x05 -> result=0x00, zero=1, carry=0; then CMP acc=0x03, a=0x04 -> carry=1, zero=0, result stays 0x00, wr_en=0.
REQ-031 MUL acc=0x10, a=0x11 -> busy 9 cycles, done in 9th cycle after acceptance, result=0x10, carry=1; start pulses during busy ignored.
REQ-032 SHL acc=0x81, a=0x03 -> done at latency 4, result=0x08, carry=0; SHR acc=0x81, a=0x00 -> latency 1, result=0x81, carry=0.
REQ-033 Start MUL, assert reset in 4th EXEC cycle -> next cycle IDLE, all outputs 0, no done pulse; new ADD accepted immediately after.
REQ-034 op=12 -> done=1, illegal=1, wr_en=0, result and flags unchanged from the prior operation.

Source files
------------

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: single-cycle ALU ops, bit-serial shifts and an
// 8-step shift-add multiplier, sequenced by an IDLE/EXEC/DONE controller.
module exec_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_acc,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         wr_en,
    output logic         zero,
    output logic         carry,
    output logic         illegal
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    // Multiplier bits consumed per EXEC cycle so that any W finishes in 8 steps.
    localparam int         MUL_D     = (W + 7) / 8;
    localparam logic [3:0] MUL_STEPS = 4'd8;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_q;
    logic [3:0]     op_q;
    logic [3:0]     cnt_q;
    logic [W-1:0]   work_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   result_q;
    logic           zero_q, carry_q, busy_q, done_q, wr_en_q, illegal_q;

    logic [W:0]     sum_w, diff_w;
    logic [W-1:0]   alu_res;
    logic           alu_carry, alu_zero, alu_wr, alu_flags, alu_ill;
    logic [W-1:0]   sh_next;
    logic           sh_out;
    logic [2*W-1:0] prod_next;

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign wr_en   = wr_en_q;
    assign zero    = zero_q;
    assign carry   = carry_q;
    assign illegal = illegal_q;

    // Single-cycle ALU evaluated on the live inputs at the accepting edge.
    always_comb begin
        sum_w     = {1'b0, operand_acc} + {1'b0, operand_a};
        diff_w    = {1'b0, operand_acc} - {1'b0, operand_a};
        alu_res   = result_q;
        alu_carry = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
        alu_ill   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum_w[W-1:0];
                alu_carry = sum_w[W];
            end
            OP_SUB: begin
                alu_res   = diff_w[W-1:0];
                alu_carry = diff_w[W];
            end
            OP_AND: alu_res = operand_acc & operand_a;
            OP_OR:  alu_res = operand_acc | operand_a;
            OP_XOR: alu_res = operand_acc ^ operand_a;
            OP_MOV: alu_res = operand_a;
            // Only reached for a zero shift count: pass the accumulator through.
            OP_SHL, OP_SHR: alu_res = operand_acc;
            OP_CMP: begin
                alu_carry = diff_w[W];
                alu_wr    = 1'b0;
            end
            default: begin
                alu_wr    = 1'b0;
                alu_flags = 1'b0;
                alu_ill   = 1'b1;
            end
        endcase
        alu_zero = (op == OP_CMP) ? (diff_w[W-1:0] == '0) : (alu_res == '0);
    end

    // One iterative step of the shifter and the shift-add multiplier.
    always_comb begin
        if (op_q == OP_SHL) begin
            sh_next = {work_q[W-2:0], 1'b0};
            sh_out  = work_q[W-1];
        end else begin
            sh_next = {1'b0, work_q[W-1:1]};
            sh_out  = work_q[0];
        end
        prod_next = prod_q + (mcand_q * {{(2*W-MUL_D){1'b0}}, mplier_q[MUL_D-1:0]});
    end

    // Controller with registered outputs; result/flags change only entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            work_q    <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        busy_q <= 1'b1;
                        if (op == OP_MUL) begin
                            state_q  <= EXEC;
                            cnt_q    <= MUL_STEPS;
                            prod_q   <= '0;
                            mcand_q  <= {{W{1'b0}}, operand_acc};
                            mplier_q <= operand_a;
                        end else if ((op == OP_SHL || op == OP_SHR) && operand_a[2:0] != 3'd0) begin
                            state_q <= EXEC;
                            cnt_q   <= {1'b0, operand_a[2:0]};
                            work_q  <= operand_acc;
                        end else begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            wr_en_q   <= alu_wr;
                            illegal_q <= alu_ill;
                            if (alu_wr) begin
                                result_q <= alu_res;
                            end
                            if (alu_flags) begin
                                zero_q  <= alu_zero;
                                carry_q <= alu_carry;
                            end
                        end
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (op_q == OP_MUL) begin
                        prod_q   <= prod_next;
                        mcand_q  <= mcand_q << MUL_D;
                        mplier_q <= mplier_q >> MUL_D;
                        if (cnt_q == 4'd1) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            wr_en_q  <= 1'b1;
                            result_q <= prod_next[W-1:0];
                            zero_q   <= (prod_next[W-1:0] == '0);
                            carry_q  <= |prod_next[2*W-1:W];
                        end
                    end else begin
                        work_q <= sh_next;
                        if (cnt_q == 4'd1) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            wr_en_q  <= 1'b1;
                            result_q <= sh_next;
                            zero_q   <= (sh_next == '0);
                            carry_q  <= sh_out;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_exec_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   op;
    logic [W-1:0] operand_a, operand_acc;
    logic         busy, done, wr_en, zero, carry, illegal;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model architectural state
    int m_res, m_zero, m_carry;

    // Observations from the most recent issued operation
    int         o_lat, o_bcnt;
    logic [7:0] o_res;
    logic       o_c, o_z, o_we, o_ill, o_bz, o_pb, o_pd;

    exec_unit #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_acc (operand_acc),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .wr_en       (wr_en),
        .zero        (zero),
        .carry       (carry),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Expected behaviour computed from the operation's definition.
    task automatic model(input logic [3:0] o, input logic [7:0] acc8, input logic [7:0] a8,
                         output int lat, output logic we, output logic ill);
        int acc, a, k, p;
        acc = int'(acc8);
        a   = int'(a8);
        k   = a % 8;
        lat = 1; we = 1'b1; ill = 1'b0;
        case (int'(o))
            0: begin p = acc + a; m_res = p % 256; m_carry = (p > 255); end
            1: begin m_res = (acc - a + 256) % 256; m_carry = (acc < a); end
            2: begin m_res = acc & a; m_carry = 0; end
            3: begin m_res = acc | a; m_carry = 0; end
            4: begin m_res = acc ^ a; m_carry = 0; end
            5: begin m_res = a; m_carry = 0; end
            6: begin m_res = (acc << k) % 256; m_carry = (k == 0) ? 0 : ((acc >> (8 - k)) & 1); lat = k + 1; end
            7: begin m_res = acc >> k; m_carry = (k == 0) ? 0 : ((acc >> (k - 1)) & 1); lat = k + 1; end
            8: begin p = acc * a; m_res = p % 256; m_carry = (p > 255); lat = 9; end
            9: begin m_zero = (acc == a); m_carry = (acc < a); we = 1'b0; end
            default: begin we = 1'b0; ill = 1'b1; end
        endcase
        if (int'(o) <= 8) m_zero = (m_res == 0);
    endtask

    // Issue one op from IDLE (called at a negedge), wait for done, then step into IDLE.
    task automatic issue(input logic [3:0] o, input logic [7:0] acc, input logic [7:0] a, input bit poke);
        start = 1'b1; op = o; operand_a = a; operand_acc = acc;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); operand_a = 8'($urandom); operand_acc = 8'($urandom);
        o_lat = 1; o_bcnt = 0;
        while (done !== 1'b1 && o_lat < 40) begin
            if (busy === 1'b1) o_bcnt++;
            if (poke) begin start = 1'($urandom); op = 4'($urandom); end
            @(negedge clk);
            o_lat++;
        end
        if (busy === 1'b1) o_bcnt++;
        o_res = result; o_c = carry; o_z = zero; o_we = wr_en; o_ill = illegal; o_bz = busy;
        start = poke;
        @(negedge clk);
        o_pb = busy; o_pd = done;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_acc = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, wr_en, zero, carry, illegal, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b z=%b c=%b ill=%b res=%h exp all 0",
                     busy, done, wr_en, zero, carry, illegal, result);
        end
        reset = 1'b0;
        m_res = 0; m_zero = 0; m_carry = 0;
    endtask

    task automatic test_add();
        issue(4'd0, 8'hF0, 8'h20, 1'b0);
        n_tests++;
        if (o_lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d exp 1", o_lat); end
        n_tests++;
        if ({o_res, o_c, o_z, o_we, o_ill, o_bz} !== {8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_outputs got res=%h c=%b z=%b we=%b ill=%b busy=%b exp res=10 c=1 z=0 we=1 ill=0 busy=1",
                     o_res, o_c, o_z, o_we, o_ill, o_bz);
        end
        n_tests++;
        if ({o_pb, o_pd} !== 2'b00) begin n_fail++; $display("FAIL add_return_idle got busy=%b done=%b exp 0 0", o_pb, o_pd); end
    endtask

    task automatic test_sub_cmp();
        issue(4'd1, 8'h05, 8'h05, 1'b0);
        n_tests++;
        if ({o_res, o_z, o_c, o_we} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL sub_outputs got res=%h z=%b c=%b we=%b exp 00 1 0 1", o_res, o_z, o_c, o_we);
        end
        issue(4'd9, 8'h03, 8'h04, 1'b0);
        n_tests++;
        if ({o_res, o_z, o_c, o_we, o_ill} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL cmp_outputs got res=%h z=%b c=%b we=%b ill=%b exp 00 0 1 0 0", o_res, o_z, o_c, o_we, o_ill);
        end
        n_tests++;
        if (o_lat !== 1) begin n_fail++; $display("FAIL cmp_latency got %0d exp 1", o_lat); end
    endtask

    task automatic test_mul();
        issue(4'd8, 8'h10, 8'h11, 1'b1);
        n_tests++;
        if (o_lat !== 9) begin n_fail++; $display("FAIL mul_latency got %0d exp 9", o_lat); end
        n_tests++;
        if (o_bcnt !== 9) begin n_fail++; $display("FAIL mul_busy_cycles got %0d exp 9", o_bcnt); end
        n_tests++;
        if ({o_res, o_c, o_z, o_we} !== {8'h10, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL mul_outputs got res=%h c=%b z=%b we=%b exp 10 1 0 1", o_res, o_c, o_z, o_we);
        end
        n_tests++;
        if ({o_pb, o_pd} !== 2'b00) begin n_fail++; $display("FAIL start_in_done got busy=%b done=%b exp 0 0", o_pb, o_pd); end
    endtask

    task automatic test_shift();
        issue(4'd6, 8'h81, 8'h03, 1'b0);
        n_tests++;
        if ({o_lat, o_res, o_c} !== {32'd4, 8'h08, 1'b0}) begin
            n_fail++; $display("FAIL shl3 got lat=%0d res=%h c=%b exp 4 08 0", o_lat, o_res, o_c);
        end
        issue(4'd7, 8'h81, 8'h00, 1'b0);
        n_tests++;
        if ({o_lat, o_res, o_c, o_z} !== {32'd1, 8'h81, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL shr0 got lat=%0d res=%h c=%b z=%b exp 1 81 0 0", o_lat, o_res, o_c, o_z);
        end
        issue(4'd7, 8'h81, 8'h01, 1'b0);
        n_tests++;
        if ({o_lat, o_res, o_c} !== {32'd2, 8'h40, 1'b1}) begin
            n_fail++; $display("FAIL shr1 got lat=%0d res=%h c=%b exp 2 40 1", o_lat, o_res, o_c);
        end
    endtask

    task automatic test_illegal();
        issue(4'd0, 8'hFF, 8'h01, 1'b0);
        issue(4'd12, 8'h37, 8'h5A, 1'b0);
        n_tests++;
        if ({o_lat, o_ill, o_we} !== {32'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL illegal_pulse got lat=%0d ill=%b we=%b exp 1 1 0", o_lat, o_ill, o_we);
        end
        n_tests++;
        if ({o_res, o_z, o_c} !== {8'h00, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL illegal_hold got res=%h z=%b c=%b exp 00 1 1", o_res, o_z, o_c);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        saw_done = 1'b0;
        start = 1'b1; op = 4'd8; operand_acc = 8'hFF; operand_a = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (saw_done !== 1'b0 || {busy, done, wr_en, zero, carry, illegal, result} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs got early_done=%b busy=%b done=%b we=%b z=%b c=%b ill=%b res=%h exp all 0",
                     saw_done, busy, done, wr_en, zero, carry, illegal, result);
        end
        reset = 1'b0;
        issue(4'd0, 8'h12, 8'h34, 1'b0);
        n_tests++;
        if ({o_lat, o_res, o_we, o_c} !== {32'd1, 8'h46, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL add_after_abort got lat=%0d res=%h we=%b c=%b exp 1 46 1 0", o_lat, o_res, o_we, o_c);
        end
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [7:0] acc, a;
        int         e_lat;
        logic       e_we, e_ill;
        bit         poke;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_res = 0; m_zero = 0; m_carry = 0;
        for (int i = 0; i < 80; i++) begin
            o    = 4'($urandom);
            acc  = 8'($urandom);
            a    = ($urandom % 5 == 0) ? acc : 8'($urandom);
            poke = ($urandom % 4 == 0);
            model(o, acc, a, e_lat, e_we, e_ill);
            issue(o, acc, a, poke);
            n_tests++;
            if ({o_lat, o_res, o_c, o_z, o_we, o_ill} !==
                {e_lat, 8'(m_res), m_carry[0], m_zero[0], e_we, e_ill}) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%0d acc=%h a=%h got lat=%0d res=%h c=%b z=%b we=%b ill=%b exp lat=%0d res=%h c=%b z=%b we=%b ill=%b",
                         i, o, acc, a, o_lat, o_res, o_c, o_z, o_we, o_ill,
                         e_lat, 8'(m_res), m_carry[0], m_zero[0], e_we, e_ill);
            end
            n_tests++;
            if (o_bcnt !== e_lat || o_pb !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_busy[%0d] op=%0d got busy_cycles=%0d idle_busy=%b exp %0d 0", i, o, o_bcnt, o_pb, e_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_mul();
        test_shift();
        test_illegal();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
